// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT-16 constants, S-box table and key schedule state type
package present_pkg;
    localparam int BLOCK_W = 16;
    localparam int DEF_KEY_W = 32;
    localparam int DEF_NUM_KEYS = 8;
    localparam int DEF_ROT = 13;
    localparam int CNT_HI = 19;
    localparam int CNT_LO = 15;
    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    typedef enum logic {IDLE, EMIT} ks_state_t;
endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: 4-bit PRESENT S-box, shared by key schedule and cipher substitution layer
module present_sbox4 import present_pkg::*; (
    input  logic [3:0] x,
    output logic [3:0] y
);
    assign y = SBOX[x];
endmodule

// File: rtl/present_key_schedule.sv
// present_key_schedule: iterative round-key generator; PRESENT_KS_ZEROIZE_EN clears the key after the final handshake
module present_key_schedule import present_pkg::*; #(
    parameter int KEY_W = DEF_KEY_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int ROT = DEF_ROT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_W-1:0]   key_in,
    output logic               busy,
    output logic [BLOCK_W-1:0] rk_out,
    output logic [3:0]         rk_idx,
    output logic               rk_valid,
    input  logic               rk_ready,
    output logic               done
);
    ks_state_t state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d, rot, upd;
    logic [3:0] idx_q, idx_d, sb_out;
    logic [4:0] cnt;
    logic done_q, done_d;
    assign rot = (key_q << ROT) | (key_q >> (KEY_W - ROT));
    assign cnt = {1'b0, idx_q} + 5'd1;
    present_sbox4 u_sbox (.x(rot[KEY_W-1 -: 4]), .y(sb_out));
    always_comb begin
        upd = {sb_out, rot[KEY_W-5:0]};
        upd[CNT_HI:CNT_LO] = upd[CNT_HI:CNT_LO] ^ cnt;
    end
    always_comb begin
        state_d = state_q;
        key_d = key_q;
        idx_d = idx_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = EMIT;
                key_d = key_in;
                idx_d = '0;
            end
        end else if (rk_ready) begin
            if (idx_q == 4'(NUM_KEYS - 1)) begin
                state_d = IDLE;
                idx_d = '0;
                done_d = 1'b1;
`ifdef PRESENT_KS_ZEROIZE_EN
                key_d = '0;
`endif
            end else begin
                key_d = upd;
                idx_d = idx_q + 4'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q <= '0;
            idx_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            idx_q <= idx_d;
            done_q <= done_d;
        end
    end
    assign busy = state_q == EMIT;
    assign rk_valid = state_q == EMIT;
    assign rk_out = key_q[KEY_W-1 -: BLOCK_W];
    assign rk_idx = idx_q;
    assign done = done_q;
endmodule

// File: tb/tb_present_key_schedule.sv
// tb_present_key_schedule: randomized self-checking bench against a bit-level key schedule model
module tb_present_key_schedule;
    localparam int KW = 32;
    localparam int NK = 8;
    localparam int RT = 13;
    logic clk = 0, rst = 0, start = 0, rk_ready = 0;
    logic [KW-1:0] key_in = '0;
    logic busy, rk_valid, done;
    logic [15:0] rk_out;
    logic [3:0] rk_idx;
    int total = 0, bad = 0;
    logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [15:0] acc_out [16];
    logic [3:0] acc_idx [16];
    int acc_cyc [16];
    int n_acc, n_done, stall_bad, done_cyc;
    logic timeout;
    logic [15:0] after_out;

    present_key_schedule #(.KEY_W(KW), .NUM_KEYS(NK), .ROT(RT)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
        .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid),
        .rk_ready(rk_ready), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] model_upd(input logic [KW-1:0] k, input int c);
        logic [KW-1:0] t;
        for (int i = 0; i < KW; i++) t[(i + RT) % KW] = k[i];
        t[KW-1:KW-4] = sb[t[KW-1:KW-4]];
        for (int i = 0; i < 5; i++) t[15 + i] = t[15 + i] ^ ((c >> i) & 1);
        return t;
    endfunction

    function automatic logic [15:0] exp_rk(input logic [KW-1:0] key, input int n);
        logic [KW-1:0] k = key;
        for (int j = 1; j <= n; j++) k = model_upd(k, j);
        return k[KW-1:KW-16];
    endfunction

    function automatic logic [15:0] exp_after(input logic [KW-1:0] key);
`ifdef PRESENT_KS_ZEROIZE_EN
        return 16'h0000;
`else
        return exp_rk(key, NK - 1);
`endif
    endfunction

    // Runs one schedule with a random consumer, recording accepted keys and done timing.
    task automatic collect(input logic [KW-1:0] key, input int prob);
        logic held = 0;
        logic [15:0] h_out = '0;
        logic [3:0] h_idx = '0;
        logic fin = 0;
        n_acc = 0; n_done = 0; stall_bad = 0; timeout = 0; done_cyc = -1; after_out = '0;
        start = 1; key_in = key;
        tick();
        start = 0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (n_done > 0 && !done) fin = 1;
            else begin
                if (done) begin
                    n_done++;
                    done_cyc = c;
                    after_out = rk_out;
                end
                if (held && (rk_out !== h_out || rk_idx !== h_idx || rk_valid !== 1'b1)) stall_bad++;
                rk_ready = ($urandom_range(0, 99) < prob);
                held = 0;
                if (rk_valid && rk_ready) begin
                    if (n_acc < 16) begin
                        acc_out[n_acc] = rk_out;
                        acc_idx[n_acc] = rk_idx;
                        acc_cyc[n_acc] = c;
                    end
                    n_acc++;
                end else if (rk_valid) begin
                    held = 1; h_out = rk_out; h_idx = rk_idx;
                end
                tick();
            end
        end
        timeout = !fin;
        rk_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; key_in = 32'hDEADBEEF;
        tick(); tick();
        start = 0;
        total++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b valid=%b done=%b idx=%0d out=%h exp all zero",
                     busy, rk_valid, done, rk_idx, rk_out);
        end
        rst = 0;
        tick();
        total++;
        if (rk_valid !== 1'b0) begin
            bad++; $display("FAIL reset_idle_valid got=%b exp=0", rk_valid);
        end
    endtask

    task automatic test_zero_key();
        logic [15:0] kv [3] = '{16'h0000, 16'hC000, 16'h5001};
        collect('0, 100);
        total++;
        if (timeout || n_acc !== NK) begin
            bad++; $display("FAIL zero_count got=%0d timeout=%b exp=%0d", n_acc, timeout, NK);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (acc_out[i] !== kv[i]) begin
                bad++; $display("FAIL zero_key%0d got=%h exp=%h", i, acc_out[i], kv[i]);
            end
        end
        for (int i = 0; i < NK && i < n_acc; i++) begin
            total++;
            if (acc_out[i] !== exp_rk('0, i) || acc_idx[i] !== 4'(i) || acc_cyc[i] !== i) begin
                bad++;
                $display("FAIL zero_seq%0d got out=%h idx=%0d cyc=%0d exp out=%h idx=%0d cyc=%0d",
                         i, acc_out[i], acc_idx[i], acc_cyc[i], exp_rk('0, i), i, i);
            end
        end
        total++;
        if (n_done !== 1 || done_cyc !== NK) begin
            bad++; $display("FAIL zero_done got pulses=%0d cyc=%0d exp 1 at %0d", n_done, done_cyc, NK);
        end
        total++;
        if (after_out !== exp_after('0)) begin
            bad++; $display("FAIL zero_after got=%h exp=%h", after_out, exp_after('0));
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [KW-1:0] k = $urandom;
            int errs = 0;
            collect(k, 55);
            for (int i = 0; i < NK && i < n_acc; i++)
                if (acc_out[i] !== exp_rk(k, i) || acc_idx[i] !== 4'(i)) errs++;
            total++;
            if (errs != 0 || n_acc !== NK || timeout) begin
                bad++; $display("FAIL rand_seq key=%h got accepted=%0d wrong=%0d exp accepted=%0d wrong=0",
                                k, n_acc, errs, NK);
            end
            total++;
            if (stall_bad !== 0 || n_done !== 1) begin
                bad++; $display("FAIL rand_stall key=%h got unstable=%0d done=%0d exp 0 and 1", k, stall_bad, n_done);
            end
            total++;
            if (after_out !== exp_after(k)) begin
                bad++; $display("FAIL rand_after key=%h got=%h exp=%h", k, after_out, exp_after(k));
            end
        end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        logic seen_done = 0;
        start = 1; key_in = '0;
        tick();
        start = 0; rk_ready = 1;
        tick();
        rk_ready = 0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (rk_out !== 16'hC000 || rk_idx !== 4'd1 || rk_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d got out=%h idx=%0d valid=%b exp C000 1 1", c, rk_out, rk_idx, rk_valid);
            end
            tick();
        end
        rk_ready = 1;
        for (int i = 1; i < NK; i++) begin
            if (rk_out !== exp_rk('0, i) || rk_idx !== 4'(i) || !rk_valid) errs++;
            tick();
        end
        seen_done = done;
        rk_ready = 0;
        total++;
        if (errs != 0 || !seen_done) begin
            bad++; $display("FAIL bp_resume got wrong=%0d done=%b exp 0 1", errs, seen_done);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        logic [KW-1:0] ka = $urandom, kb = ~ka;
        int errs = 0;
        start = 1; key_in = ka;
        tick();
        start = 0; rk_ready = 1;
        for (int i = 0; i < NK; i++) begin
            if (i >= 1 && i <= 3) begin start = 1; key_in = kb; end
            else start = 0;
            if (rk_out !== exp_rk(ka, i) || rk_idx !== 4'(i) || !rk_valid) errs++;
            tick();
        end
        start = 0; rk_ready = 0;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL ign_seq got wrong=%0d exp 0", errs);
        end
        total++;
        if (done !== 1'b1) begin
            bad++; $display("FAIL ign_done got=%b exp=1", done);
        end
        tick();
        total++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL ign_idle got valid=%b busy=%b done=%b exp 0 0 0", rk_valid, busy, done);
        end
    endtask

    task automatic test_reset_mid();
        logic [KW-1:0] k = $urandom;
        int errs = 0;
        start = 1; key_in = k;
        tick();
        start = 0; rk_ready = 1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (rk_idx !== 4'd3) begin
            bad++; $display("FAIL rm_pre got idx=%0d exp=3", rk_idx);
        end
        rst = 1;
        tick();
        rst = 0; rk_ready = 0;
        total++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_idx !== 4'd0 || done !== 1'b0) begin
            bad++; $display("FAIL rm_abort got valid=%b busy=%b idx=%0d done=%b exp 0 0 0 0", rk_valid, busy, rk_idx, done);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL rm_nodone got=%b exp=0", done);
        end
        collect(k, 100);
        for (int i = 0; i < NK && i < n_acc; i++)
            if (acc_out[i] !== exp_rk(k, i) || acc_idx[i] !== 4'(i)) errs++;
        total++;
        if (errs != 0 || n_acc !== NK || n_done !== 1) begin
            bad++; $display("FAIL rm_restart got wrong=%0d accepted=%0d done=%0d exp 0 %0d 1", errs, n_acc, n_done, NK);
        end
    endtask

    task automatic test_back_to_back();
        logic [KW-1:0] k1 = $urandom, k2 = $urandom;
        int errs = 0;
        start = 1; key_in = k1;
        tick();
        key_in = k2; rk_ready = 1;
        for (int i = 0; i < NK; i++) begin
            if (rk_out !== exp_rk(k1, i) || rk_idx !== 4'(i) || !rk_valid) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL b2b_first got wrong=%0d exp 0", errs);
        end
        total++;
        if (done !== 1'b1 || rk_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_gap got done=%b valid=%b exp 1 0", done, rk_valid);
        end
        tick();
        start = 0;
        total++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk_out !== k2[KW-1:KW-16] || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_second got valid=%b idx=%0d out=%h exp 1 0 %h", rk_valid, rk_idx, rk_out, k2[KW-1:KW-16]);
        end
        errs = 0;
        for (int i = 0; i < NK; i++) begin
            if (rk_out !== exp_rk(k2, i) || rk_idx !== 4'(i) || !rk_valid) errs++;
            tick();
        end
        rk_ready = 0;
        total++;
        if (errs != 0 || done !== 1'b1 || rk_out !== exp_after(k2)) begin
            bad++; $display("FAIL b2b_drain got wrong=%0d done=%b out=%h exp 0 1 %h", errs, done, rk_out, exp_after(k2));
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
